// File: rtl/blink_pwm_n_if.sv
// Control and status bundle for blink_pwm_n.
// master drives EN/LOAD/PERIOD/DUTY/MODE; slave drives COUNT/TICK/O.
interface blink_pwm_n_if #(
  parameter int WIDTH = 26,
  parameter int N     = 4
);
  logic             EN;
  logic             LOAD;
  logic [WIDTH-1:0] PERIOD;
  logic [N*WIDTH-1:0] DUTY;
  logic [2*N-1:0]   MODE;
  logic [WIDTH-1:0] COUNT;
  logic             TICK;
  logic [N-1:0]     O;

  modport master (
    output EN, LOAD, PERIOD, DUTY, MODE,
    input  COUNT, TICK, O
  );

  modport slave (
    input  EN, LOAD, PERIOD, DUTY, MODE,
    output COUNT, TICK, O
  );
endinterface

// File: rtl/blink_pwm_n.sv
// N-channel blinker/PWM with shadowed frame parameters.
// Ports: CLK, RESETB (sync, active-low), bus (slave): EN, LOAD, PERIOD, DUTY, MODE -> COUNT, TICK, O.
module blink_pwm_n #(
  parameter int WIDTH = 26,
  parameter int N     = 4
) (
  input logic          CLK,
  input logic          RESETB,
  blink_pwm_n_if.slave bus
);
  localparam logic [WIDTH-1:0] HALF =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_ON  = 2'b01;
  localparam logic [1:0] M_PWM = 2'b10;
  localparam logic [1:0] M_TGL = 2'b11;

  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   period_act;
  logic [WIDTH-1:0]   period_pnd;
  logic [N*WIDTH-1:0] duty_act;
  logic [N*WIDTH-1:0] duty_pnd;
  logic [2*N-1:0]     mode_act;
  logic [2*N-1:0]     mode_pnd;
  logic               pend_q;
  logic               tick_q;
  logic [N-1:0]       o_q;
  logic [N-1:0]       o_d;
  logic               wrap;

  assign wrap = bus.EN && (count_q == period_act);

  assign bus.COUNT = count_q;
  assign bus.TICK  = tick_q;
  assign bus.O     = o_q;

  always_comb begin
    o_d = o_q;
    for (int i = 0; i < N; i++) begin
      unique case (mode_act[2*i +: 2])
        M_OFF: o_d[i] = 1'b0;
        M_ON:  o_d[i] = 1'b1;
        M_PWM: o_d[i] =
          count_q < duty_act[i*WIDTH +: WIDTH];
        M_TGL: o_d[i] = wrap ? ~o_q[i] : o_q[i];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      o_q        <= '0;
      pend_q     <= 1'b0;
      period_act <= '1;
      duty_act   <= {N{HALF}};
      mode_act   <= {N{M_PWM}};
      period_pnd <= '0;
      duty_pnd   <= '0;
      mode_pnd   <= '0;
    end else begin
      if (bus.EN) begin
        count_q <= wrap ? '0 : count_q + 1'b1;
        o_q     <= o_d;
      end
      tick_q <= wrap;
      // A LOAD landing on the wrap edge skips the
      // shadow stage and supersedes anything pending.
      if (wrap && bus.LOAD) begin
        period_act <= bus.PERIOD;
        duty_act   <= bus.DUTY;
        mode_act   <= bus.MODE;
        pend_q     <= 1'b0;
      end else if (wrap && pend_q) begin
        period_act <= period_pnd;
        duty_act   <= duty_pnd;
        mode_act   <= mode_pnd;
        pend_q     <= 1'b0;
      end else if (bus.LOAD) begin
        period_pnd <= bus.PERIOD;
        duty_pnd   <= bus.DUTY;
        mode_pnd   <= bus.MODE;
        pend_q     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_blink_pwm_n.sv
// Directed bench for blink_pwm_n (WIDTH=8, N=2).
// Drives the bus interface, checks COUNT/TICK/O.
module tb_blink_pwm_n;
  logic CLK;
  logic RESETB;
  int   n_chk;
  int   n_err;
  int   hi;

  blink_pwm_n_if #(.WIDTH(8), .N(2)) bus ();

  blink_pwm_n #(.WIDTH(8), .N(2)) dut (
    .CLK    (CLK),
    .RESETB (RESETB),
    .bus    (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk3(
    input string tag,
    input int    c,
    input int    t,
    input int    o
  );
    check({tag, "_cnt"}, 32'(bus.COUNT), c);
    check({tag, "_tick"}, 32'(bus.TICK), t);
    check({tag, "_o"}, 32'(bus.O), o);
  endtask

  task automatic load(
    input logic [7:0] p,
    input logic [7:0] d1,
    input logic [7:0] d0,
    input logic [3:0] m
  );
    bus.LOAD   = 1'b1;
    bus.PERIOD = p;
    bus.DUTY   = {d1, d0};
    bus.MODE   = m;
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    RESETB     = 1'b0;
    bus.EN     = 1'b0;
    bus.LOAD   = 1'b0;
    bus.PERIOD = '0;
    bus.DUTY   = '0;
    bus.MODE   = '0;
    step();
    step();
    chk3("rst", 0, 0, 0);

    // Reset defaults: 256-cycle frame, 50% duty.
    RESETB = 1'b1;
    bus.EN = 1'b1;
    for (int j = 1; j <= 512; j++) begin
      step();
      chk3("dflt", j % 256, int'(j % 256 == 0),
           ((j - 1) % 256 < 128) ? 3 : 0);
    end

    // Shadowed load at COUNT=10.
    repeat (10) step();
    check("pre_ld", 32'(bus.COUNT), 10);
    load(8'd9, 8'd20, 8'd3, 4'b1010);
    step();
    bus.LOAD = 1'b0;
    chk3("ld10", 11, 0, 3);
    for (int k = 12; k <= 255; k++) begin
      step();
      chk3("shadow", k, 0,
           (k - 1 < 128) ? 3 : 0);
    end
    step();
    chk3("wrap255", 0, 1, 0);
    hi = 0;
    for (int m = 1; m <= 20; m++) begin
      step();
      chk3("p9", m % 10, int'(m % 10 == 0),
           2 + int'((m - 1) % 10 < 3));
      if (m <= 10) hi += int'(bus.O[0]);
    end
    check("hi0", hi, 3);

    // LOAD coincident with wrap.
    repeat (9) step();
    check("pre_wr", 32'(bus.COUNT), 9);
    load(8'd4, 8'd2, 8'd2, 4'b1010);
    step();
    bus.LOAD = 1'b0;
    chk3("ldwrap", 0, 1, 2);
    for (int m = 1; m <= 10; m++) begin
      step();
      chk3("p4", m % 5, int'(m % 5 == 0),
           ((m - 1) % 5 < 2) ? 3 : 0);
    end

    // Second mid-frame LOAD overrides the first.
    step();
    chk3("ov1", 1, 0, 3);
    load(8'd7, 8'd9, 8'd9, 4'b0101);
    step();
    chk3("ov2", 2, 0, 3);
    load(8'd3, 8'd0, 8'd1, 4'b1110);
    step();
    bus.LOAD = 1'b0;
    chk3("ov3", 3, 0, 0);
    step();
    chk3("ov4", 4, 0, 0);
    step();
    chk3("ov5", 0, 1, 0);

    // Toggle on channel 1, PWM duty 1 on channel 0.
    for (int m = 1; m <= 17; m++) begin
      step();
      chk3("tgl", m % 4, int'(m % 4 == 0),
           2 * ((m / 4) % 2) +
           int'((m - 1) % 4 < 1));
    end

    // Enable low freezes everything.
    bus.EN = 1'b0;
    repeat (7) begin
      step();
      chk3("frz", 1, 0, 1);
    end
    bus.EN = 1'b1;
    step();
    chk3("res1", 2, 0, 0);
    step();
    chk3("res2", 3, 0, 0);
    step();
    chk3("res3", 0, 1, 2);

    // PERIOD=0 with DUTY0=0, DUTY1=5.
    load(8'd0, 8'd5, 8'd0, 4'b1010);
    step();
    bus.LOAD = 1'b0;
    check("p0_pnd", 32'(bus.COUNT), 1);
    step();
    step();
    step();
    check("p0_w_c", 32'(bus.COUNT), 0);
    check("p0_w_t", 32'(bus.TICK), 1);
    repeat (5) begin
      step();
      chk3("p0", 0, 1, 2);
    end

    // Reset with a pending LOAD discards it.
    bus.EN = 1'b0;
    load(8'd5, 8'd1, 8'd1, 4'b0101);
    step();
    bus.LOAD = 1'b0;
    check("tick_en0", 32'(bus.TICK), 0);
    RESETB = 1'b0;
    step();
    chk3("rst2", 0, 0, 0);
    RESETB = 1'b1;
    bus.EN = 1'b1;
    for (int m = 1; m <= 300; m++) begin
      step();
      chk3("post", m % 256, int'(m % 256 == 0),
           ((m - 1) % 256 < 128) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/blink_pwm_n.md
BLINK_PWM_N -- requirements
Module: blink_pwm_n

Interface
REQ-001 Parameter WIDTH, default 26: bit width of the period counter, PERIOD, and each duty value.
REQ-002 Parameter N, default 4: number of output channels.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESETB  input  1  reset, synchronous, active-low; sampled only on the rising edge of CLK.
REQ-005 EN  input  1  count enable; when low, the counter and outputs freeze.
REQ-006 LOAD  input  1  one-cycle strobe that captures PERIOD, DUTY and MODE into the pending registers.
REQ-007 PERIOD  input  WIDTH  terminal count; the counter sequence is 0..PERIOD, giving PERIOD+1 cycles per frame.
REQ-008 DUTY  input  N*WIDTH  per-channel duty value; channel i uses bits [i*WIDTH +: WIDTH].
REQ-009 MODE  input  2*N  per-channel mode; channel i uses bits [2i +: 2]: 00 off, 01 on, 10 PWM, 11 toggle.
REQ-010 COUNT  output  WIDTH  current counter value.
REQ-011 TICK  output  1  registered one-cycle pulse at each frame wrap.
REQ-012 O  output  N  registered channel outputs.

Function
REQ-013 Terminology: "wrap" = a cycle in which EN=1 and COUNT==period_act.
- In a wrap cycle, COUNT loads 0 on the next edge.
- Otherwise, with EN=1, COUNT increments by 1.
- COUNT never exceeds period_act, except as allowed by REQ-018.
REQ-014 With EN=0: COUNT, O and all active/pending registers hold; TICK is driven 0; LOAD is still accepted.
REQ-015 TICK is high in the cycle after a wrap, for exactly one cycle.
- period_act==0 with EN=1 holds TICK high continuously.
REQ-016 Shadowing: a LOAD pulse captures the inputs into pending registers and sets the pending flag.
- A later LOAD before the next wrap overwrites the pending values (last LOAD wins).
REQ-017 At a wrap with the pending flag set: pending values are copied into period_act, duty_act and mode_act, and the flag is cleared.
- LOAD in the same cycle as a wrap bypasses pending; the inputs go straight to the active registers on that edge.
REQ-018 Active parameters change only at frame boundaries; a mid-frame LOAD never alters the current frame.
REQ-019 Channel output on the edge following any EN=1 cycle, using the mode_act and duty_act values in force during that cycle:
- off: O[i] = 0.
- on: O[i] = 1.
- PWM: O[i] = (COUNT < duty_act[i]), unsigned compare on WIDTH bits.
- toggle: O[i] inverts on each wrap and holds otherwise.
REQ-020 PWM boundaries:
- duty 0 gives constant 0.
- duty >= period_act+1 gives constant 1.
- High time per frame = min(duty, period_act+1) cycles.
REQ-021 A mode change to toggle takes effect without a glitch: O[i] starts from its current value.
REQ-022 Arithmetic is unsigned and modulo-free. The counter is compared for equality, never allowed to overflow the register width.

Reset
REQ-023 When RESETB=0 at a rising edge, the following take these values on that edge, overriding EN and LOAD:
- COUNT = 0, TICK = 0, O = 0, pending flag = 0.
- period_act = all ones.
- duty_act[i] = 2^(WIDTH-1).
- mode_act[i] = PWM.
REQ-024 Reset defaults make every channel a free-running 50% blinker with a 2^WIDTH-cycle period and no LOAD required. O is high in the first half of each frame.
REQ-025 Reset asserted mid-frame discards pending values; the first frame after release starts at COUNT = 0.

Verification (WIDTH=8, N=2)
REQ-026 Reset defaults:
- Stimulus: RESETB low 2 cycles, then EN=1 for 512 cycles.
- Required: O[0] = O[1] = 1 for COUNT 0..127 (appearing one cycle later), 0 for 128..255; TICK every 256 cycles.
REQ-027 Shadowed load:
- Stimulus: LOAD at COUNT=10 with PERIOD=9, DUTY0=3, DUTY1=20, MODE=PWM,PWM.
- Required: the frame continues to 255; afterwards COUNT cycles 0..9, O[0] is high 3 of 10 cycles, O[1] stays high.
REQ-028 Load coincident with wrap:
- Stimulus: LOAD in the COUNT==period_act cycle with PERIOD=4.
- Required: the next frame is 0..4.
- Also: a second LOAD mid-frame overrides the first before the wrap.
REQ-029 Toggle and enable:
- Stimulus: MODE1=toggle, PERIOD=3.
- Required: O[1] toggles every 4 cycles.
- Stimulus: EN low for 7 cycles.
- Required: COUNT, O and TICK frozen (TICK = 0); resumes from the same COUNT.
REQ-030 Edge cases:
- PERIOD=0 gives TICK constantly 1 and COUNT constantly 0.
- DUTY=0 gives O constantly 0.
- RESETB pulsed low mid-frame with a LOAD pending gives the reset defaults, and the pending values are never applied.
